// File: rtl/fetch_queue.sv
// fetch_queue: in-order tracker of outstanding instruction-SRAM fetches between pre-IF and ID.
// Optional FQ_BYPASS_EN forwards a response aimed at the head entry to ID in the same cycle.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [PC_W-1:0]          req_pc,
    input  logic                     req_adef,
    output logic                     fq_allowin,
    input  logic                     inst_sram_data_ok,
    input  logic [INST_W-1:0]        inst_sram_rdata,
    input  logic                     flush,
    input  logic                     ds_allowin,
    output logic                     fs_to_ds_valid,
    output logic [INST_W+PC_W:0]     fs_to_ds_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  adef_q;
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW:0]       occupancy;
    logic              enq, deq;
    logic              discard_nz;
    logic              resp_hit, resp_take;
    logic [AW-1:0]     resp_idx, scan_idx;
    logic [CW-1:0]     pending_cnt;
    logic              head_valid, head_pending, bypass;
    logic [INST_W-1:0] head_inst;

    // Squashed-but-unanswered requests still occupy SRAM slots, so they count against capacity.
    assign occupancy  = {1'b0, count_q} + {1'b0, discard_q};
    assign fq_allowin = occupancy < (CW+1)'(DEPTH);
    assign enq        = req_valid && fq_allowin;
    assign discard_nz = |discard_q;

    always_comb begin
        resp_hit    = 1'b0;
        resp_idx    = head_q;
        scan_idx    = head_q;
        pending_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + AW'(i);
            if (valid_q[scan_idx] && pending_q[scan_idx]) begin
                pending_cnt = pending_cnt + CW'(1);
                if (!resp_hit) begin
                    resp_hit = 1'b1;
                    resp_idx = scan_idx;
                end
            end
        end
    end

    assign resp_take    = inst_sram_data_ok && !discard_nz && resp_hit;
    assign head_valid   = valid_q[head_q];
    assign head_pending = pending_q[head_q];

`ifdef FQ_BYPASS_EN
    assign bypass = inst_sram_data_ok && !discard_nz && head_valid && head_pending;
`else
    assign bypass = 1'b0;
`endif

    assign head_inst      = bypass ? inst_sram_rdata : inst_q[head_q];
    assign fs_to_ds_valid = head_valid && (!head_pending || bypass) && !flush;
    assign fs_to_ds_bus   = head_valid ? {adef_q[head_q], head_inst, pc_q[head_q]} : '0;
    assign deq            = fs_to_ds_valid && ds_allowin;

    always_comb begin
        discard_d = discard_q;
        count_d   = count_q + CW'(enq) - CW'(deq);
        head_d    = head_q + AW'(deq);
        tail_d    = tail_q + AW'(enq);
        if (flush) begin
            // A response arriving in the flush cycle is consumed before the pending entries are counted.
            discard_d = discard_q + pending_cnt
                        - CW'(inst_sram_data_ok && (discard_nz || resp_hit));
            count_d   = CW'(enq);
            head_d    = tail_q;
        end else if (inst_sram_data_ok && discard_nz) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            pending_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            discard_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            discard_q <= discard_d;
            if (resp_take) begin
                pending_q[resp_idx] <= 1'b0;
            end
            if (deq) begin
                valid_q[head_q] <= 1'b0;
            end
            if (flush) begin
                valid_q <= '0;
            end
            if (enq) begin
                valid_q[tail_q]   <= 1'b1;
                pending_q[tail_q] <= !req_adef;
            end
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (resp_take) begin
            inst_q[resp_idx] <= inst_sram_rdata;
        end
        if (enq) begin
            pc_q[tail_q]   <= req_pc;
            adef_q[tail_q] <= req_adef;
            inst_q[tail_q] <= '0;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PC_W = 32;
    localparam int INST_W = 32;
    localparam int BW = 1 + INST_W + PC_W;
`ifdef FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, req_valid, req_adef, inst_sram_data_ok, flush, ds_allowin;
    logic [PC_W-1:0] req_pc;
    logic [INST_W-1:0] inst_sram_rdata;
    logic fq_allowin, fs_to_ds_valid;
    logic [BW-1:0] fs_to_ds_bus;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        adef;
        logic        done;
        logic [31:0] inst;
    } ent_t;
    ent_t mq[$];
    int m_discard = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_pc(req_pc), .req_adef(req_adef),
        .fq_allowin(fq_allowin),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .flush(flush), .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
    );

    // ---------------- reference model ----------------
    function automatic int m_pending();
        int n = 0;
        foreach (mq[k]) if (!mq[k].done) n++;
        return n;
    endfunction

    function automatic logic exp_valid();
        if (mq.size() == 0 || flush) return 1'b0;
        if (mq[0].done) return 1'b1;
        return BYP && inst_sram_data_ok && (m_discard == 0);
    endfunction

    function automatic logic [BW-1:0] exp_bus();
        logic [31:0] inst;
        if (mq.size() == 0) return '0;
        inst = mq[0].done ? mq[0].inst : inst_sram_rdata;
        return {mq[0].adef, inst, mq[0].pc};
    endfunction

    function automatic logic [BW-1:0] mk(input logic ad, input logic [31:0] inst, input logic [31:0] pc);
        return {ad, inst, pc};
    endfunction

    task automatic model_step();
        bit allow;
        bit deq;
        bit found;
        ent_t e;
        allow = (mq.size() + m_discard) < DEPTH;
        deq = exp_valid() && ds_allowin;
        if (inst_sram_data_ok) begin
            if (m_discard > 0) m_discard--;
            else begin
                found = 0;
                for (int k = 0; k < mq.size(); k++) begin
                    if (!found && !mq[k].done) begin
                        mq[k].done = 1'b1;
                        mq[k].inst = inst_sram_rdata;
                        found = 1;
                    end
                end
            end
        end
        if (deq) void'(mq.pop_front());
        if (flush) begin
            m_discard += m_pending();
            mq.delete();
        end
        if (req_valid && allow) begin
            e.pc = req_pc; e.adef = req_adef; e.done = req_adef; e.inst = '0;
            mq.push_back(e);
        end
    endtask

    // ---------------- stimulus plumbing ----------------
    task automatic drive(input logic rv, input logic [31:0] pc, input logic ad, input logic dok,
                         input logic [31:0] rd, input logic fl, input logic dsa);
        req_valid = rv; req_pc = pc; req_adef = ad;
        inst_sram_data_ok = dok; inst_sram_rdata = rd;
        flush = fl; ds_allowin = dsa;
        #1;
    endtask

    task automatic tick();
        if (fs_to_ds_valid && ds_allowin)
            $display("deq t=%0t adef=%0b inst=%08h pc=%08h", $time,
                     fs_to_ds_bus[BW-1], fs_to_ds_bus[BW-2:PC_W], fs_to_ds_bus[PC_W-1:0]);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_discard = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        drive(1, 32'h1c000000, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h1c000004, 0, 1, 32'h5, 0, 0); tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        mq.delete(); m_discard = 0;
        #1;
        checks++;
        if (fq_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%0b want=1", fq_allowin); end
        checks++;
        if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", fs_to_ds_valid); end
        checks++;
        if (fs_to_ds_bus !== '0) begin failures++; $display("FAIL reset_bus got=%h want=0", fs_to_ds_bus); end
    endtask

    task automatic test_fill_drain();
        int n = 0;
        logic [31:0] pc, inst;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1c000000 + 32'(4 * i), 0, 0, 0, 0, 1);
            checks++;
            if (fq_allowin !== 1'b1) begin failures++; $display("FAIL fill_allowin%0d got=%0b want=1", i, fq_allowin); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (fq_allowin !== 1'b0) begin failures++; $display("FAIL full_allowin got=%0b want=0", fq_allowin); end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, i < 4, 32'hA + 32'(i), 0, 1);
            if (fs_to_ds_valid === 1'b1) begin
                pc = 32'h1c000000 + 32'(4 * n);
                inst = 32'hA + 32'(n);
                checks++;
                if (n >= 4 || fs_to_ds_bus !== mk(1'b0, inst, pc)) begin
                    failures++; $display("FAIL drain_bus%0d got=%h want=%h", n, fs_to_ds_bus, mk(1'b0, inst, pc));
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 4) begin failures++; $display("FAIL drain_count got=%0d want=4", n); end
    endtask

    task automatic test_flush_discard();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1c000010 + 32'(4 * i), 0, 0, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 1, 32'h11, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL flush_gate got=%0b want=0", fs_to_ds_valid); end
        tick();
        drive(1, 32'h1c000100, 0, 0, 0, 0, 0);
        checks++;
        if (fq_allowin !== 1'b1) begin failures++; $display("FAIL fd_allowin_a got=%0b want=1", fq_allowin); end
        tick();
        drive(1, 32'h1c000104, 0, 0, 0, 0, 0);
        checks++;
        if (fq_allowin !== 1'b1) begin failures++; $display("FAIL fd_allowin_b got=%0b want=1", fq_allowin); end
        tick();
        drive(0, 0, 0, 1, 32'h21, 0, 0);
        checks++;
        if (fq_allowin !== 1'b0) begin failures++; $display("FAIL fd_allowin_c got=%0b want=0", fq_allowin); end
        tick();
        drive(0, 0, 0, 1, 32'h22, 0, 0);
        checks++;
        if (fq_allowin !== 1'b1) begin failures++; $display("FAIL fd_allowin_d got=%0b want=1", fq_allowin); end
        checks++;
        if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL fd_drop got=%0b want=0", fs_to_ds_valid); end
        tick();
        drive(0, 0, 0, 1, 32'h33, 0, 0);
        checks++;
        if (fs_to_ds_valid !== BYP) begin failures++; $display("FAIL fd_land_lat got=%0b want=%0b", fs_to_ds_valid, BYP); end
        tick();
        drive(0, 0, 0, 1, 32'h44, 0, 1);
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== mk(1'b0, 32'h33, 32'h1c000100)) begin
            failures++; $display("FAIL fd_out0 got=%0b/%h want=1/%h", fs_to_ds_valid, fs_to_ds_bus, mk(1'b0, 32'h33, 32'h1c000100));
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== mk(1'b0, 32'h44, 32'h1c000104)) begin
            failures++; $display("FAIL fd_out1 got=%0b/%h want=1/%h", fs_to_ds_valid, fs_to_ds_bus, mk(1'b0, 32'h44, 32'h1c000104));
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (fs_to_ds_valid !== 1'b0 || fs_to_ds_bus !== '0) begin
            failures++; $display("FAIL fd_empty got=%0b/%h want=0/0", fs_to_ds_valid, fs_to_ds_bus);
        end
    endtask

    task automatic test_flush_same_cycle();
        do_reset();
        drive(1, 32'h1c000200, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h1c000204, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h1c000208, 0, 1, 32'h55, 1, 0);
        checks++;
        if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL fs_gate got=%0b want=0", fs_to_ds_valid); end
        tick();
        drive(0, 0, 0, 1, 32'h66, 0, 0);
        checks++;
        if (fq_allowin !== 1'b1) begin failures++; $display("FAIL fs_allowin got=%0b want=1", fq_allowin); end
        tick();
        drive(0, 0, 0, 1, 32'h77, 0, 0);
        checks++;
        if (fs_to_ds_valid !== BYP) begin failures++; $display("FAIL fs_drop got=%0b want=%0b", fs_to_ds_valid, BYP); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== mk(1'b0, 32'h77, 32'h1c000208)) begin
            failures++; $display("FAIL fs_out got=%0b/%h want=1/%h", fs_to_ds_valid, fs_to_ds_bus, mk(1'b0, 32'h77, 32'h1c000208));
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL fs_empty got=%0b want=0", fs_to_ds_valid); end
    endtask

    task automatic test_adef();
        logic [BW-1:0] want [3];
        int n = 0;
        want[0] = mk(1'b0, 32'hC0, 32'h1c000000);
        want[1] = mk(1'b1, 32'h0, 32'h1c000003);
        want[2] = mk(1'b0, 32'hC1, 32'h1c000008);
        do_reset();
        drive(1, 32'h1c000000, 0, 0, 0, 0, 1); tick();
        drive(1, 32'h1c000003, 1, 0, 0, 0, 1); tick();
        drive(1, 32'h1c000008, 0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, i < 2, 32'hC0 + 32'(i), 0, 1);
            if (fs_to_ds_valid === 1'b1) begin
                checks++;
                if (n >= 3 || fs_to_ds_bus !== want[n % 3]) begin
                    failures++; $display("FAIL adef_out%0d got=%h want=%h", n, fs_to_ds_bus, want[n % 3]);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 3) begin failures++; $display("FAIL adef_count got=%0d want=3", n); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] want [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            want[i] = mk(1'b0, 32'hD0 + 32'(i), 32'h1c000300 + 32'(4 * i));
            drive(1, 32'h1c000300 + 32'(4 * i), 0, 0, 0, 0, 0); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 32'hD0 + 32'(i), 0, 0); tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== want[0] || fq_allowin !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d got=%0b/%h/%0b want=1/%h/0", i, fs_to_ds_valid, fs_to_ds_bus, fq_allowin, want[0]);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== want[i]) begin
                failures++; $display("FAIL bp_release%0d got=%0b/%h want=1/%h", i, fs_to_ds_valid, fs_to_ds_bus, want[i]);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (fs_to_ds_valid !== 1'b0 || fq_allowin !== 1'b1) begin
            failures++; $display("FAIL bp_empty got=%0b/%0b want=0/1", fs_to_ds_valid, fq_allowin);
        end
    endtask

    task automatic test_latency();
        do_reset();
        drive(1, 32'h1c000400, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 32'hEE, 0, 0);
        checks++;
        if (fs_to_ds_valid !== BYP) begin failures++; $display("FAIL lat_same got=%0b want=%0b", fs_to_ds_valid, BYP); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== mk(1'b0, 32'hEE, 32'h1c000400)) begin
            failures++; $display("FAIL lat_next got=%0b/%h want=1/%h", fs_to_ds_valid, fs_to_ds_bus, mk(1'b0, 32'hEE, 32'h1c000400));
        end
        tick();
    endtask

    task automatic test_random();
        logic dok;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (m_discard + m_pending() > 0) dok = $urandom_range(0, 1) == 1;
            else dok = $urandom_range(0, 15) == 0;
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0, dok,
                  $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            checks++;
            if (fq_allowin !== ((mq.size() + m_discard) < DEPTH)) begin
                failures++; $display("FAIL rnd_allowin cyc=%0d got=%0b want=%0b", i, fq_allowin, (mq.size() + m_discard) < DEPTH);
            end
            checks++;
            if (fs_to_ds_valid !== exp_valid()) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", i, fs_to_ds_valid, exp_valid());
            end
            if (exp_valid() || mq.size() == 0) begin
                checks++;
                if (fs_to_ds_bus !== exp_bus()) begin
                    failures++; $display("FAIL rnd_bus cyc=%0d got=%h want=%h", i, fs_to_ds_bus, exp_bus());
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_flush_discard();
        test_flush_same_cycle();
        test_adef();
        test_backpressure();
        test_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage sitting between pre-IF and ID. It tracks up to DEPTH in-order outstanding instruction-SRAM requests, each with its PC and address-error flag. It matches returning `data_ok` responses to the oldest pending entry and presents completed instructions to ID in program order. On a branch-redirect flush it drops responses still in flight for cancelled requests.

## Interface
Parameters:
- DEPTH, 4, max outstanding entries (power of 2, 2..8)
- PC_W, 32, PC width
- INST_W, 32, instruction width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  pre-IF request issued/accepted this cycle
- req_pc  in  PC_W  PC of the request
- req_adef  in  1  address-error request; no SRAM response will come
- fq_allowin  out  1  queue can take a request this cycle
- inst_sram_data_ok  in  1  one response returned
- inst_sram_rdata  in  INST_W  response data
- flush  in  1  branch-taken cancel; squash all queued entries
- ds_allowin  in  1  ID accepts this cycle
- fs_to_ds_valid  out  1  head entry complete and presented
- fs_to_ds_bus  out  1+INST_W+PC_W  {adef, inst, pc}

## Operation
- Each entry holds valid, pending, adef, pc, inst. It is a circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count register of log2(DEPTH)+1 bits.
- `discard` counter, log2(DEPTH)+1 bits, counts in-flight responses owed to squashed requests.
- `fq_allowin = (count + discard) < DEPTH`. This bounds total SRAM outstanding to DEPTH.
- Enqueue when `req_valid && fq_allowin`: write at tail, set valid, and set `pending = !req_adef`.
  - adef entry: complete at enqueue with inst = 0.
  - `req_valid` while `!fq_allowin` is a protocol error; the request is ignored.
- Response when `data_ok`:
  - If `discard != 0`: decrement discard; data dropped.
  - Otherwise: write rdata to the oldest entry (searching from head) with pending=1, and clear its pending.
  - `data_ok` with no pending entry and `discard == 0` is ignored.
- Output: `fs_to_ds_valid = head.valid && !head.pending && !flush`. Dequeue (advance head) when `fs_to_ds_valid && ds_allowin`.
- Flush: clears all entry valid bits, head = tail, count = 0. Also `discard <= discard + (#pending entries) - (data_ok && discard==0 ? 1 : 0) - (data_ok && discard!=0 ? 1 : 0)`, i.e. the same-cycle response is consumed first.
- Simultaneous flush + req_valid: the request is the redirect target and is enqueued into the emptied queue (count becomes 1).
- Simultaneous enqueue + dequeue at count == DEPTH is impossible, since fq_allowin is already 0.

## Timing
- Reset values:
  - Queue empty; count = 0, discard = 0.
  - fq_allowin = 1, fs_to_ds_valid = 0.
  - fs_to_ds_bus = 0 while the queue is empty.
- Latency without bypass: response in cycle N, entry visible at output in cycle N+1.
- adef entry: visible the cycle after enqueue.
- Throughput: one enqueue, one response and one dequeue per cycle, concurrently.
- Reset mid-operation: all state cleared next edge; in-flight responses are not tracked (the SRAM controller is reset together with this block).

## Configuration
- `FQ_BYPASS_EN` defined: if `data_ok` targets the head entry (head pending, discard == 0), then `fs_to_ds_valid` and inst come combinationally from rdata in the same cycle.
  - Zero-latency, matching single-entry fetch behaviour.
  - If ID accepts, the entry dequeues without being written.
- Undefined: registered path only, one-cycle response-to-output latency. No combinational path from rdata/data_ok to outputs.

## Test plan
- DEPTH=4. Enqueue PCs 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c back to back → fq_allowin drops to 0 after the 4th. Responses 0xA, 0xB, 0xC, 0xD with ds_allowin=1 → bus emits them in order with matching PCs.
- Enqueue 3 requests, 1 response, then flush → discard = 2, fq_allowin = 1 while count + 2 < 4. Next 2 data_ok dropped; the 3rd response lands on the post-flush entry.
- Flush in the same cycle as data_ok and req_valid with 2 pending → discard = 1, count = 1, new PC queued.
- req_adef=1 at PC 0x1c000003 between two normal requests → output order is normal, {adef=1, inst=0}, normal. Only 2 data_ok are consumed.
- ds_allowin=0 for 5 cycles with 4 completed entries → fs_to_ds_valid held, bus stable, fq_allowin=0. Release → 4 dequeues in 4 cycles.
- With FQ_BYPASS_EN, response to an empty-except-head queue → fs_to_ds_valid=1 in the same cycle as data_ok. Without the macro → one cycle later.
